// File: rtl/pc_fetch_sequencer.sv
// rtl/pc_fetch_sequencer.sv - fetch-stage PC and instruction-memory sequencer
//
// Purpose: decides each cycle whether the PC register is written (reset
// vector, sequential PC + 4 or redirect target), issues one instruction-memory
// request at a time and holds the returned instruction until decode takes it.
//
// Optional feature macro: PC_MISALIGN_TRAP_EN (redirects with bit 1 set go to
// TRAP_VECTOR and pulse misalign_fault).
//
// Ports:
//   clk, reset                    clock, synchronous active-low reset
//   pc_cur / pc_en / pc_next      PC register read value, write enable, write data
//   redirect_valid/_target        branch/jump redirect pulse and address
//   imem_req/_addr/_ready         request handshake to instruction memory
//   imem_rvalid/_rdata            instruction memory read response
//   if_valid/_pc/_instr/if_ready  held instruction towards decode
//   misalign_fault                one-cycle pulse on a trapped redirect
module pc_fetch_sequencer #(
    parameter int                   ADDR_SIZE    = 32,
    parameter logic [ADDR_SIZE-1:0] RESET_VECTOR = '0,
    parameter logic [ADDR_SIZE-1:0] TRAP_VECTOR  = ADDR_SIZE'(4)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_SIZE-1:0] pc_cur,
    output logic                 pc_en,
    output logic [ADDR_SIZE-1:0] pc_next,
    input  logic                 redirect_valid,
    input  logic [ADDR_SIZE-1:0] redirect_target,
    output logic                 imem_req,
    output logic [ADDR_SIZE-1:0] imem_addr,
    input  logic                 imem_ready,
    input  logic                 imem_rvalid,
    input  logic [31:0]          imem_rdata,
    output logic                 if_valid,
    output logic [ADDR_SIZE-1:0] if_pc,
    output logic [31:0]          if_instr,
    input  logic                 if_ready,
    output logic                 misalign_fault
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    logic [1:0]           state_q, state_d;
    logic                 pend_v_q, pend_v_d;
    logic [ADDR_SIZE-1:0] pend_addr_q, pend_addr_d;
    logic [ADDR_SIZE-1:0] if_pc_q, if_pc_d;
    logic [31:0]          if_instr_q, if_instr_d;

    logic [ADDR_SIZE-1:0] redir_now;
    logic [ADDR_SIZE-1:0] redir_val;
    logic [ADDR_SIZE-1:0] redir_pc;
    logic                 redir_trap;

    logic                 pc_en_c;
    logic [ADDR_SIZE-1:0] pc_next_c;
    logic                 req_c;
    logic                 valid_c;
    logic                 fault_c;

    always_comb begin
        // Halfword-aligned redirect value; a live redirect beats the stored one.
        redir_now = redirect_target & ~ADDR_SIZE'(1);
        redir_val = redirect_valid ? redir_now : pend_addr_q;
`ifdef PC_MISALIGN_TRAP_EN
        redir_trap = redir_val[1];
`else
        redir_trap = 1'b0;
`endif
        redir_pc = redir_trap ? TRAP_VECTOR : redir_val;

        state_d     = state_q;
        pend_v_d    = pend_v_q;
        pend_addr_d = pend_addr_q;
        if_pc_d     = if_pc_q;
        if_instr_d  = if_instr_q;
        pc_en_c     = 1'b0;
        pc_next_c   = '0;
        req_c       = 1'b0;
        valid_c     = 1'b0;
        fault_c     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pc_en_c   = 1'b1;
                pc_next_c = RESET_VECTOR;
                state_d   = ST_REQ;
            end
            ST_REQ: begin
                // The request stays up even if a redirect arrives; the redirect
                // is remembered and applied when the response comes back.
                req_c = 1'b1;
                if (redirect_valid) begin
                    pend_v_d    = 1'b1;
                    pend_addr_d = redir_now;
                end
                if (imem_ready) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (imem_rvalid) begin
                    if (redirect_valid || pend_v_q) begin
                        pc_en_c   = 1'b1;
                        pc_next_c = redir_pc;
                        fault_c   = redir_trap;
                        pend_v_d  = 1'b0;
                        state_d   = ST_REQ;
                    end else begin
                        if_instr_d = imem_rdata;
                        if_pc_d    = pc_cur;
                        state_d    = ST_HOLD;
                    end
                end else if (redirect_valid) begin
                    pend_v_d    = 1'b1;
                    pend_addr_d = redir_now;
                end
            end
            ST_HOLD: begin
                // A redirect squashes the held instruction in the same cycle.
                valid_c = !redirect_valid;
                if (redirect_valid) begin
                    pc_en_c   = 1'b1;
                    pc_next_c = redir_pc;
                    fault_c   = redir_trap;
                    state_d   = ST_REQ;
                end else if (if_ready) begin
                    pc_en_c   = 1'b1;
                    pc_next_c = pc_cur + ADDR_SIZE'(4);
                    state_d   = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            pend_v_q    <= 1'b0;
            pend_addr_q <= '0;
            if_pc_q     <= '0;
            if_instr_q  <= '0;
        end else begin
            state_q     <= state_d;
            pend_v_q    <= pend_v_d;
            pend_addr_q <= pend_addr_d;
            if_pc_q     <= if_pc_d;
            if_instr_q  <= if_instr_d;
        end
    end

    // Every output is forced low while reset is asserted.
    assign pc_en          = reset & pc_en_c;
    assign pc_next        = reset ? pc_next_c : '0;
    assign imem_req       = reset & req_c;
    assign imem_addr      = reset ? pc_cur : '0;
    assign if_valid       = reset & valid_c;
    assign if_pc          = reset ? if_pc_q : '0;
    assign if_instr       = reset ? if_instr_q : '0;
    assign misalign_fault = reset & fault_c;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb/tb_pc_fetch_sequencer.sv - self-checking bench for pc_fetch_sequencer
module tb_pc_fetch_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0004;
`ifdef PC_MISALIGN_TRAP_EN
    localparam logic [31:0] MIS_PC  = 32'h0000_0004;
    localparam logic [31:0] MIS_FLT = 32'h1;
`else
    localparam logic [31:0] MIS_PC  = 32'h0000_0102;
    localparam logic [31:0] MIS_FLT = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc_cur = 32'hDEAD_BEE0;
    logic        pc_en;
    logic [31:0] pc_next;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready = 1'b0;
    logic        misalign_fault;

    always #5 clk = ~clk;

    pc_fetch_sequencer dut (
        .clk(clk), .reset(reset), .pc_cur(pc_cur), .pc_en(pc_en), .pc_next(pc_next),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready),
        .misalign_fault(misalign_fault)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Memory contents: a fixed hash of the word address.
    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Next PC for a redirect value: {fault, pc}.
    function automatic logic [32:0] resolve(input logic [31:0] a);
        logic [31:0] v;
        v = a & ~32'h1;
`ifdef PC_MISALIGN_TRAP_EN
        if (v[1]) return {1'b1, TV};
`endif
        return {1'b0, v};
    endfunction

    // Stimulus knobs: 0 = low, 1 = high, 2 = random.
    int k_ready = 1, k_ifr = 1, k_lat_min = 1, k_lat_max = 1;
    int k_redir_pct = 0, k_spur_pct = 0;
    logic rst_drv = 1'b0;
    logic os_rd_v = 1'b0;
    logic [31:0] os_rd_t = '0;
    logic os_rv = 1'b0;

    // Reference model: what the fetch unit is currently waiting for.
    logic m_start = 1'b1, m_wacc = 1'b0, m_wdat = 1'b0, m_hold = 1'b0;
    logic m_pend = 1'b0;
    logic [31:0] m_pend_addr = '0, m_pc = 32'hDEAD_BEE0, m_hpc = '0, m_hins = '0;

    // Memory model and PC register datapath.
    logic mem_out = 1'b0;
    logic [31:0] mem_addr = '0;
    int mem_cnt = 0;
    logic [31:0] pc_reg = 32'hDEAD_BEE0;

    logic s_pc_en, s_req, s_ifv, s_fault;
    logic [31:0] s_pc_next, s_addr, s_ifpc, s_ifins;

    task automatic tick();
        logic e_pc_en, e_req, e_ifv, e_flt;
        logic [31:0] e_pc_next;
        logic [32:0] r;
        logic mem_resp;
        @(negedge clk);
        reset   = rst_drv;
        pc_cur  = pc_reg;
        imem_ready = (k_ready == 2) ? ($urandom_range(0, 99) < 70) : k_ready[0];
        if_ready   = (k_ifr == 2) ? ($urandom_range(0, 99) < 60) : k_ifr[0];
        if (os_rd_v) begin
            redirect_valid  = 1'b1;
            redirect_target = os_rd_t;
        end else begin
            redirect_valid  = ($urandom_range(0, 99) < k_redir_pct);
            redirect_target = $urandom;
            if ($urandom_range(0, 1) == 1) redirect_target[31:12] = '0;
        end
        mem_resp = mem_out && (mem_cnt == 0);
        if (mem_resp) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word(mem_addr);
        end else if (os_rv || (!mem_out && $urandom_range(0, 99) < k_spur_pct)) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hBAD0_BAD0;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        os_rd_v = 1'b0;
        os_rv   = 1'b0;
        #1;
        s_pc_en = pc_en; s_pc_next = pc_next; s_req = imem_req; s_addr = imem_addr;
        s_ifv = if_valid; s_ifpc = if_pc; s_ifins = if_instr; s_fault = misalign_fault;

        e_pc_en = 1'b0; e_pc_next = '0; e_req = 1'b0; e_ifv = 1'b0; e_flt = 1'b0;
        if (!reset) begin
            e_pc_en = 1'b0;
        end else if (m_start) begin
            e_pc_en = 1'b1; e_pc_next = RV;
        end else if (m_wacc) begin
            e_req = 1'b1;
        end else if (m_wdat) begin
            if (imem_rvalid && (redirect_valid || m_pend)) begin
                r = resolve(redirect_valid ? redirect_target : m_pend_addr);
                e_pc_en = 1'b1; e_pc_next = r[31:0]; e_flt = r[32];
            end
        end else if (m_hold) begin
            e_ifv = !redirect_valid;
            if (redirect_valid) begin
                r = resolve(redirect_target);
                e_pc_en = 1'b1; e_pc_next = r[31:0]; e_flt = r[32];
            end else if (if_ready) begin
                e_pc_en = 1'b1; e_pc_next = m_pc + 32'd4;
            end
        end

        chk("pc_en", s_pc_en, e_pc_en);
        if (e_pc_en || !reset) chk("pc_next", s_pc_next, e_pc_next);
        chk("imem_req", s_req, e_req);
        if (e_req || !reset) chk("imem_addr", s_addr, reset ? m_pc : 32'h0);
        chk("if_valid", s_ifv, e_ifv);
        if (e_ifv || !reset) begin
            chk("if_pc", s_ifpc, reset ? m_hpc : 32'h0);
            chk("if_instr", s_ifins, reset ? m_hins : 32'h0);
        end
        chk("misalign_fault", s_fault, e_flt);
        if (reset && s_ifv && if_ready) chk("deliver_word", s_ifins, word(s_ifpc));

        @(posedge clk);
        if (s_pc_en) pc_reg = s_pc_next;
        if (!reset) begin
            m_start = 1'b1; m_wacc = 1'b0; m_wdat = 1'b0; m_hold = 1'b0;
            m_pend = 1'b0; m_hpc = '0; m_hins = '0;
            mem_out = 1'b0; mem_cnt = 0;
        end else begin
            if (e_pc_en) m_pc = e_pc_next;
            if (m_start) begin
                m_start = 1'b0; m_wacc = 1'b1;
            end else if (m_wacc) begin
                if (redirect_valid) begin m_pend = 1'b1; m_pend_addr = redirect_target; end
                if (imem_ready) begin m_wacc = 1'b0; m_wdat = 1'b1; end
            end else if (m_wdat) begin
                if (imem_rvalid) begin
                    m_wdat = 1'b0;
                    if (e_pc_en) begin
                        m_wacc = 1'b1; m_pend = 1'b0;
                    end else begin
                        m_hold = 1'b1; m_hpc = m_pc; m_hins = imem_rdata;
                    end
                end else if (redirect_valid) begin
                    m_pend = 1'b1; m_pend_addr = redirect_target;
                end
            end else if (m_hold) begin
                if (e_pc_en) begin m_hold = 1'b0; m_wacc = 1'b1; end
            end
            if (mem_resp) mem_out = 1'b0;
            if (s_req && imem_ready) begin
                mem_out  = 1'b1;
                mem_addr = s_addr;
                mem_cnt  = int'($urandom_range(k_lat_min, k_lat_max)) - 1;
            end else if (mem_out && mem_cnt > 0) begin
                mem_cnt--;
            end
        end
    endtask

    initial begin
        logic [31:0] addrs[$];
        int vcyc[$];
        int nv;

        // Reset and straight-line fetch 0x0, 0x4, 0x8.
        repeat (3) tick();
        chk("rst_req", s_req, 32'h0);
        chk("rst_pc_en", s_pc_en, 32'h0);
        rst_drv = 1'b1;
        tick();
        chk("t1_pc_en", s_pc_en, 32'h1);
        chk("t1_pc_next", s_pc_next, RV);
        for (int t = 1; t <= 9; t++) begin
            tick();
            if (s_req && imem_ready) addrs.push_back(s_addr);
            if (s_ifv) vcyc.push_back(t);
        end
        chk("seq_count", addrs.size(), 32'd3);
        chk("seq_vcount", vcyc.size(), 32'd3);
        if (addrs.size() == 3 && vcyc.size() == 3) begin
            chk("seq_a0", addrs[0], 32'h0);
            chk("seq_a1", addrs[1], 32'h4);
            chk("seq_a2", addrs[2], 32'h8);
            chk("seq_v0", vcyc[0], 32'd3);
            chk("seq_v1", vcyc[1], 32'd6);
            chk("seq_v2", vcyc[2], 32'd9);
        end

        // Stalled request with redirect to 0x100 in the wait window.
        rst_drv = 1'b0; tick();
        rst_drv = 1'b1; k_ready = 0; tick();
        nv = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin os_rd_v = 1'b1; os_rd_t = 32'h100; end
            tick();
            chk("stall_req", s_req, 32'h1);
            chk("stall_addr", s_addr, 32'h0);
            nv += int'(s_ifv);
        end
        k_ready = 1; tick();
        chk("acc_addr", s_addr, 32'h0);
        tick();
        chk("disc_pc_en", s_pc_en, 32'h1);
        chk("disc_pc_next", s_pc_next, 32'h100);
        nv += int'(s_ifv);
        chk("disc_no_valid", nv, 32'd0);
        tick();
        chk("redir_addr", s_addr, 32'h100);
        tick();

        // Redirect beats if_ready in HOLD; bit 0 dropped.
        os_rd_v = 1'b1; os_rd_t = 32'h41; tick();
        chk("hold_drop_valid", s_ifv, 32'h0);
        chk("hold_pc_en", s_pc_en, 32'h1);
        chk("hold_pc_next", s_pc_next, 32'h40);
        tick();
        chk("hold_next_addr", s_addr, 32'h40);

        // Wrap from 0xFFFF_FFFC to 0.
        os_rd_v = 1'b1; os_rd_t = 32'hFFFF_FFFC; tick();
        chk("wrap_redir", s_pc_next, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr", s_addr, 32'hFFFF_FFFC);
        tick();
        tick();
        chk("wrap_ifpc", s_ifpc, 32'hFFFF_FFFC);
        chk("wrap_pc_next", s_pc_next, 32'h0);
        k_lat_min = 3; k_lat_max = 3;
        tick();
        chk("wrap_next_addr", s_addr, 32'h0);

        // Reset during RESP, late rvalid after release.
        rst_drv = 1'b0; tick();
        chk("mid_rst_req", s_req, 32'h0);
        chk("mid_rst_pc_en", s_pc_en, 32'h0);
        chk("mid_rst_ifv", s_ifv, 32'h0);
        chk("mid_rst_ifpc", s_ifpc, 32'h0);
        tick();
        rst_drv = 1'b1; k_ready = 0; k_lat_min = 1; k_lat_max = 1;
        os_rv = 1'b1; tick();
        chk("rel_pc_en", s_pc_en, 32'h1);
        chk("rel_pc_next", s_pc_next, RV);
        os_rv = 1'b1; tick();
        chk("rel_req_addr", s_addr, RV);
        chk("rel_req_ifv", s_ifv, 32'h0);
        k_ready = 1; tick();
        tick();
        k_ifr = 0; tick();
        chk("rel_instr", s_ifins, word(RV));
        chk("rel_ifv", s_ifv, 32'h1);

        // Misaligned redirect to 0x102.
        os_rd_v = 1'b1; os_rd_t = 32'h102; tick();
        chk("mis_pc_next", s_pc_next, MIS_PC);
        chk("mis_fault", s_fault, MIS_FLT);
        tick();
        chk("mis_fault_end", s_fault, 32'h0);
        chk("mis_addr", s_addr, MIS_PC);

        // Randomized traffic against the model.
        k_ready = 2; k_ifr = 2; k_lat_min = 1; k_lat_max = 3;
        k_redir_pct = 15; k_spur_pct = 20;
        for (int i = 0; i < 3000; i++) begin
            if (!rst_drv) rst_drv = 1'b1;
            else if ($urandom_range(0, 199) == 0) rst_drv = 1'b0;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_fetch_sequencer.md
# pc_fetch_sequencer

Fetch-stage controller that sequences the PC register and the instruction-memory port. Each cycle it decides whether the PC is written and with what value: the reset vector, the sequential PC + 4, or a branch/jump redirect target. It issues one instruction-memory request at a time and holds the returned instruction for decode until decode accepts it. It sits between the PC/address-adder datapath, the branch-decision logic and the ID stage.

## Interface
- `ADDR_SIZE`, 32, PC and memory address width.
- `RESET_VECTOR`, 32'h0000_0000, first fetch address after reset.
- `TRAP_VECTOR`, 32'h0000_0004, target used on a misaligned redirect (only with the macro).

- `clk` in 1: the single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `pc_cur` in ADDR_SIZE: current PC register value.
- `pc_en` out 1: PC write enable.
- `pc_next` out ADDR_SIZE: PC write data.
- `redirect_valid` in 1: branch taken or jump, single-cycle pulse.
- `redirect_target` in ADDR_SIZE: redirect address, valid with `redirect_valid`.
- `imem_req` out 1: fetch request.
- `imem_addr` out ADDR_SIZE: fetch address, equal to `pc_cur`.
- `imem_ready` in 1: memory accepts the request this cycle.
- `imem_rvalid` in 1: read data valid.
- `imem_rdata` in 32: instruction word.
- `if_valid` out 1: instruction available to decode.
- `if_pc` out ADDR_SIZE: PC of the held instruction.
- `if_instr` out 32: held instruction.
- `if_ready` in 1: decode accepts the instruction.
- `misalign_fault` out 1: one-cycle pulse when a misaligned redirect is trapped.

## Operation
- States: IDLE, REQ, RESP, HOLD. At most one memory request is outstanding.
- Pending-redirect register: `pend_v` and `pend_addr`.
  - A `redirect_valid` pulse arriving in REQ or RESP is captured into it.
  - A newer redirect overwrites an older one.
- The PC is written only on a transition into REQ. The next PC value is chosen as:
  - IDLE → REQ: `RESET_VECTOR`.
  - Redirect in the transition cycle: `redirect_target`.
  - Else, if `pend_v` is set: `pend_addr`.
  - Else: `pc_cur + 4`, modulo 2^ADDR_SIZE (wraps from 0xFFFF_FFFC to 0).
- Bit 0 of every redirect value is forced to 0.
- IDLE: drive `pc_en`=1 and go to REQ.
- REQ: drive `imem_req`=1.
  - `imem_req` and `imem_addr` stay stable until `imem_ready`; a redirect never withdraws a request.
  - On `imem_ready`, go to RESP.
- RESP: wait for `imem_rvalid`.
  - If `pend_v` is set or `redirect_valid` is high: discard the data, write the PC with the redirect value, clear `pend_v`, go to REQ.
  - Otherwise: latch `if_instr`←`imem_rdata` and `if_pc`←`pc_cur`, go to HOLD.
- HOLD: drive `if_valid`=1, except in a cycle where `redirect_valid` is high.
  - `redirect_valid` takes priority over `if_ready`: the instruction is dropped and the PC is written with the target, then go to REQ.
  - Else, on `if_ready`: write the PC with `pc_cur + 4` and go to REQ.
- `imem_rvalid` is ignored outside RESP.

## Timing
- While `reset` is low, all outputs are 0.
- The edge that samples `reset` low sets the state to IDLE and clears `pend_v`, `if_pc` and `if_instr`.
- Reset mid-operation behaves the same: any outstanding response is abandoned. The memory side must be reset by the same `reset`.
- First cycle after reset goes high: IDLE, `pc_en`=1, `pc_next`=`RESET_VECTOR`.
- Next cycle: REQ with `imem_addr`=`RESET_VECTOR`.
- `pc_en` and `pc_next` are combinational from state and inputs. The PC updates on the same edge as the state transition.
- Minimum cost per instruction is 3 cycles: REQ (accepted), RESP (`rvalid` the next cycle), HOLD (`if_ready`).
- Redirect-to-fetch latency:
  - From HOLD: the redirected address appears on `imem_addr` in the next cycle.
  - From REQ or RESP: after the current response returns.

## Configuration
- `PC_MISALIGN_TRAP_EN` defined:
  - A redirect value with bit 1 set is not used as the next PC; `pc_next`=`TRAP_VECTOR` is written instead.
  - `misalign_fault` pulses for that one cycle.
- `PC_MISALIGN_TRAP_EN` undefined:
  - Bit 1 passes through unchanged.
  - `misalign_fault` is tied to 0.

## Test plan
- Reset release, memory always ready, `rvalid` one cycle after accept, `if_ready`=1 → fetch addresses 0x0, 0x4, 0x8, with one `if_valid` every 3 cycles.
- `imem_ready` held low 4 cycles in REQ, with `redirect_valid` pulsed at target 0x100 in that window:
  - `imem_addr` holds 0x0 until accept.
  - The 0x0 response is discarded; `if_valid` never rises for it.
  - The next request is to 0x100.
- `redirect_valid` at 0x41 in HOLD with `if_ready`=1 in the same cycle → instruction dropped, `pc_next`=0x40, next `imem_addr`=0x40.
- `pc_cur`=0xFFFF_FFFC with the instruction accepted → `pc_next`=0x0.
- `reset` pulled low during RESP → all outputs 0. After release, IDLE, then fetch from `RESET_VECTOR`; a late `rvalid` in IDLE or REQ is ignored.
- With `PC_MISALIGN_TRAP_EN`, redirect to 0x102 → `misalign_fault` for 1 cycle, `pc_next`=0x4. Without the macro: `pc_next`=0x102, `misalign_fault`=0.
